byte_serializer: RTL and testbench

BYTE_SERIALIZER -- requirements
Module: byte_serializer

---
 rtl/byte_serializer.sv | 118 +++++++++++
 tb/tb_byte_serializer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_serializer.sv
// byte_serializer: buffers parallel words in a small FIFO and shifts each one
// out LSB first, one bit per clock, with no gap between queued words.
//
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_valid/o_ready: input handshake; a word is taken on i_valid && o_ready
//   i_data         : parallel word (bit 0 leaves first)
//   o_a            : serial bit stream
//   o_bit_idx      : index of the bit currently on o_a
//   o_frame_start  : high while bit 0 of a word is on o_a
//   o_busy         : high while a word is being shifted out
//   o_count        : FIFO occupancy
module byte_serializer #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [W-1:0]                 i_data,
  output logic                         o_a,
  output logic [$clog2(W)-1:0]         o_bit_idx,
  output logic                         o_frame_start,
  output logic                         o_busy,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned IW = $clog2(W);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t         state;
  logic [W-1:0]   mem [DEPTH];
  logic [W-1:0]   shift_reg;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;

  logic           push_c;
  logic           pop_c;
  logic           last_bit_c;
  logic [IW-1:0]  bit_nxt_c;
  logic [CW-1:0]  count_nxt_c;

  // Handshake and pop decode; o_ready is a flop, so i_valid never reaches it.
  assign push_c      = i_valid & o_ready;
  assign last_bit_c  = (o_bit_idx == IW'(W - 1));
  assign pop_c       = (o_count != '0) &&
                       ((state == IDLE) || ((state == SHIFT) && last_bit_c));
  assign bit_nxt_c   = o_bit_idx + IW'(1);
  assign count_nxt_c = o_count + CW'(push_c) - CW'(pop_c);

  // FIFO storage; never visible on outputs unless a valid entry is popped.
  always_ff @(posedge i_clk) begin
    if (push_c) begin
      mem[wr_ptr] <= i_data;
    end
  end

  // Pointers, occupancy and registered ready.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
      o_ready <= 1'b1;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      o_count <= count_nxt_c;
      o_ready <= (count_nxt_c != CW'(DEPTH));
    end
  end

  // Shift FSM with registered serial outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      shift_reg     <= '0;
      o_a           <= 1'b0;
      o_bit_idx     <= '0;
      o_frame_start <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      if (pop_c) begin
        // Load the head word and present bit 0 straight away; this also
        // covers the back-to-back case at the last bit of the previous word.
        state         <= SHIFT;
        shift_reg     <= mem[rd_ptr];
        o_a           <= mem[rd_ptr][0];
        o_bit_idx     <= '0;
        o_frame_start <= 1'b1;
        o_busy        <= 1'b1;
      end else if ((state == SHIFT) && !last_bit_c) begin
        o_a           <= shift_reg[bit_nxt_c];
        o_bit_idx     <= bit_nxt_c;
        o_frame_start <= 1'b0;
        o_busy        <= 1'b1;
      end else begin
        state         <= IDLE;
        o_a           <= 1'b0;
        o_bit_idx     <= '0;
        o_frame_start <= 1'b0;
        o_busy        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_byte_serializer.sv
// Self-checking bench for byte_serializer (W=8, DEPTH=4). Accepted words go
// into a scoreboard queue; a negedge monitor pops one per frame start and
// checks every serial bit and bit index against it.
module tb_byte_serializer;

  localparam int unsigned W     = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned IW    = $clog2(W);
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst_n;
  logic          valid;
  logic          ready;
  logic [W-1:0]  data;
  logic          a;
  logic [IW-1:0] bit_idx;
  logic          fs;
  logic          busy;
  logic [CW-1:0] count;

  int n_cmp    = 0;
  int n_fail   = 0;
  int mon_cmp  = 0;
  int mon_fail = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] cur;
  int           mon_idx;

  byte_serializer #(.W(W), .DEPTH(DEPTH)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_valid       (valid),
    .o_ready       (ready),
    .i_data        (data),
    .o_a           (a),
    .o_bit_idx     (bit_idx),
    .o_frame_start (fs),
    .o_busy        (busy),
    .o_count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stream monitor: every busy cycle must carry the next bit of the head word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) begin
        if (fs) begin
          mon_cmp++;
          if (q.size() == 0) begin
            mon_fail++;
            $display("FAIL mon_unexpected_word got word starting bit %0b want no word", a);
          end else begin
            cur = q.pop_front();
          end
          mon_idx = 0;
        end else begin
          mon_idx++;
        end
        mon_cmp++;
        if (mon_idx >= int'(W) || bit_idx !== IW'(mon_idx) || a !== cur[IW'(mon_idx)]) begin
          mon_fail++;
          $display("FAIL mon_bit got idx=%0d a=%0b want idx=%0d a=%0b (word %h)",
                   bit_idx, a, mon_idx, cur[IW'(mon_idx)], cur);
        end
      end else begin
        mon_cmp++;
        if (a !== 1'b0 || fs !== 1'b0 || bit_idx !== '0) begin
          mon_fail++;
          $display("FAIL mon_idle got a=%0b fs=%0b idx=%0d want 0 0 0", a, fs, bit_idx);
        end
      end
    end
  end

  task automatic drive(input logic [W-1:0] d, output bit acc);
    valid = 1'b1;
    data  = d;
    acc   = ready;
    @(posedge clk);
    #1;
    valid = 1'b0;
    if (acc) q.push_back(d);
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!busy && count == '0 && q.size() == 0) done = 1;
    end
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_drain got busy=%0b count=%0d queued=%0d want 0 0 0",
               name, busy, count, q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    valid = 1'b0;
    data  = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({a, busy, fs, ready, bit_idx, count} !== {4'b0001, IW'(0), CW'(0)}) begin
      n_fail++;
      $display("FAIL reset_state got a=%0b busy=%0b fs=%0b ready=%0b idx=%0d count=%0d want 0 0 0 1 0 0",
               a, busy, fs, ready, bit_idx, count);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    bit acc;
    logic [W-1:0] w = 8'hA5;
    wait_idle("single_pre");
    drive(w, acc);
    n_cmp++;
    if (acc !== 1'b1) begin
      n_fail++;
      $display("FAIL single_accept got %0b want 1", acc);
    end
    for (int k = 0; k < int'(W); k++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({busy, fs, bit_idx, a} !== {1'b1, (k == 0), IW'(k), w[IW'(k)]}) begin
        n_fail++;
        $display("FAIL single_bit%0d got busy=%0b fs=%0b idx=%0d a=%0b want 1 %0b %0d %0b",
                 k, busy, fs, bit_idx, a, (k == 0), k, w[IW'(k)]);
      end
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, fs, a, bit_idx} !== {3'b000, IW'(0)}) begin
      n_fail++;
      $display("FAIL single_idle got busy=%0b fs=%0b a=%0b idx=%0d want 0 0 0 0", busy, fs, a, bit_idx);
    end
  endtask

  task automatic test_back_to_back();
    bit acc;
    int starts = 0;
    int drops  = 0;
    wait_idle("b2b_pre");
    drive(8'h01, acc);
    drive(8'h80, acc);
    drive(8'hFF, acc);
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      if (!busy) drops++;
      if (fs) starts++;
    end
    n_cmp++;
    if (drops != 0) begin
      n_fail++;
      $display("FAIL b2b_busy got %0d idle cycles want 0", drops);
    end
    n_cmp++;
    if (starts != 2) begin
      n_fail++;
      $display("FAIL b2b_frame_starts got %0d want 2", starts);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end got busy=%0b want 0", busy);
    end
  endtask

  task automatic test_full();
    bit acc;
    logic [W-1:0] words [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    wait_idle("full_pre");
    for (int i = 0; i < 5; i++) begin
      drive(words[i], acc);
      n_cmp++;
      if (acc !== 1'b1) begin
        n_fail++;
        $display("FAIL full_accept%0d got %0b want 1", i, acc);
      end
    end
    n_cmp++;
    if ({ready, count} !== {1'b0, CW'(DEPTH)}) begin
      n_fail++;
      $display("FAIL full_state got ready=%0b count=%0d want 0 %0d", ready, count, DEPTH);
    end
    drive(8'h66, acc);
    n_cmp++;
    if ({acc, ready, count} !== {2'b00, CW'(DEPTH)}) begin
      n_fail++;
      $display("FAIL full_drop got acc=%0b ready=%0b count=%0d want 0 0 %0d", acc, ready, count, DEPTH);
    end
    wait_idle("full");
  endtask

  task automatic test_push_pop();
    bit acc;
    wait_idle("pp_pre");
    drive(8'hC3, acc);
    n_cmp++;
    if ({busy, count} !== {1'b0, CW'(1)}) begin
      n_fail++;
      $display("FAIL pp_first got busy=%0b count=%0d want 0 1", busy, count);
    end
    drive(8'h3C, acc);
    n_cmp++;
    if ({busy, fs, count} !== {2'b11, CW'(1)}) begin
      n_fail++;
      $display("FAIL pp_same_edge got busy=%0b fs=%0b count=%0d want 1 1 1", busy, fs, count);
    end
    wait_idle("pp");
  endtask

  task automatic test_reset_mid();
    bit acc;
    wait_idle("rm_pre");
    drive(8'hF0, acc);
    drive(8'h0F, acc);
    drive(8'h5A, acc);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bit_idx, count} !== {IW'(3), CW'(2)}) begin
      n_fail++;
      $display("FAIL rm_pre_state got idx=%0d count=%0d want 3 2", bit_idx, count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({a, busy, fs, ready, bit_idx, count} !== {4'b0001, IW'(0), CW'(0)}) begin
      n_fail++;
      $display("FAIL rm_async got a=%0b busy=%0b fs=%0b ready=%0b idx=%0d count=%0d want 0 0 0 1 0 0",
               a, busy, fs, ready, bit_idx, count);
    end
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, ready, count} !== {2'b01, CW'(0)}) begin
      n_fail++;
      $display("FAIL rm_release got busy=%0b ready=%0b count=%0d want 0 1 0", busy, ready, count);
    end
    drive(8'h96, acc);
    wait_idle("rm_new");
  endtask

  task automatic test_wrap();
    bit acc;
    int got   = 0;
    int guard = 0;
    wait_idle("wrap_pre");
    while (got < 3 * int'(DEPTH) && guard < 400) begin
      guard++;
      if ($urandom_range(0, 2) != 0) begin
        drive(W'($urandom), acc);
        if (acc) got++;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    n_cmp++;
    if (got != 3 * int'(DEPTH)) begin
      n_fail++;
      $display("FAIL wrap_accepted got %0d want %0d", got, 3 * DEPTH);
    end
    wait_idle("wrap");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_push_pop();
    test_reset_mid();
    test_wrap();
    repeat (2) @(posedge clk);
    n_cmp++;
    if (mon_cmp == 0) begin
      n_fail++;
      $display("FAIL monitor_active got %0d checks want >0", mon_cmp);
    end
    n_cmp  += mon_cmp;
    n_fail += mon_fail;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
